zap_tag_ram_ctrl: RTL and testbench

Controller and arbiter for one single-cycle-clear tag RAM (DEPTH entries of WIDTH-bit tags plus a valid bit, 1-cycle read latency).
- Shares the single read port between two lookup requesters (instruction side, data side).
- Sequences refill writes and whole-array invalidates from the page walker/CP15.
- Performs tag comparison and returns a hit/miss response one cycle after grant.

---
 rtl/zap_tag_ram_ctrl.sv | 143 ++++++++++++++
 tb/tb_zap_tag_ram_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_tag_ram_ctrl.sv
// Tag RAM controller: arbitrates two lookup ports, sequences refill/invalidate, compares tags.
// Optional ZAP_TAG_CTRL_FWD_EN forwards a same-cycle refill tag to a same-index lookup.
module zap_tag_ram_ctrl #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32,
    localparam int IDXW = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req0,
    input  logic [IDXW-1:0]  i_idx0,
    input  logic [WIDTH-1:0] i_tag0,
    input  logic             i_req1,
    input  logic [IDXW-1:0]  i_idx1,
    input  logic [WIDTH-1:0] i_tag1,
    output logic             o_gnt0,
    output logic             o_gnt1,
    output logic             o_rsp_valid,
    output logic             o_rsp_id,
    output logic             o_rsp_hit,
    input  logic             i_wr_req,
    input  logic [IDXW-1:0]  i_wr_idx,
    input  logic [WIDTH-1:0] i_wr_tag,
    output logic             o_wr_ack,
    input  logic             i_inv_req,
    output logic             o_inv_ack,
    output logic             o_mem_ren,
    output logic             o_mem_wen,
    output logic             o_mem_inv,
    output logic [IDXW-1:0]  o_mem_raddr,
    output logic [IDXW-1:0]  o_mem_waddr,
    output logic [WIDTH-1:0] o_mem_wdata,
    input  logic [WIDTH-1:0] i_mem_rdata,
    input  logic             i_mem_rdav
);

    logic             active;
    logic             inv_c;
    logic             wr_c;
    logic             hazard0;
    logic             hazard1;
    logic             elig0;
    logic             elig1;
    logic             gnt0;
    logic             gnt1;
    logic             gnt_any;
    logic [IDXW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_tag;
    logic             hit_raw;

    logic             last_gnt;
    logic             pend_v;
    logic             pend_id;
    logic [WIDTH-1:0] pend_tag;

`ifdef ZAP_TAG_CTRL_FWD_EN
    logic             fwd_v;
    logic [WIDTH-1:0] fwd_tag;
`endif

    always_comb begin
        active  = ~i_reset;
        inv_c   = active & i_inv_req;
        wr_c    = active & i_wr_req & ~i_inv_req;
`ifdef ZAP_TAG_CTRL_FWD_EN
        hazard0 = 1'b0;
        hazard1 = 1'b0;
`else
        // Same-index read must wait so it observes the refilled entry.
        hazard0 = wr_c & (i_idx0 == i_wr_idx);
        hazard1 = wr_c & (i_idx1 == i_wr_idx);
`endif
        elig0   = active & i_req0 & ~i_inv_req & ~hazard0;
        elig1   = active & i_req1 & ~i_inv_req & ~hazard1;
        gnt0    = elig0 & (~elig1 | last_gnt);
        gnt1    = elig1 & (~elig0 | ~last_gnt);
        gnt_any = gnt0 | gnt1;
        gnt_idx = gnt1 ? i_idx1 : i_idx0;
        gnt_tag = gnt1 ? i_tag1 : i_tag0;
    end

    always_comb begin
        o_gnt0      = gnt0;
        o_gnt1      = gnt1;
        o_inv_ack   = inv_c;
        o_mem_inv   = inv_c;
        o_wr_ack    = wr_c;
        o_mem_wen   = wr_c;
        o_mem_waddr = wr_c ? i_wr_idx : '0;
        o_mem_wdata = wr_c ? i_wr_tag : '0;
        o_mem_ren   = gnt_any;
        o_mem_raddr = gnt_any ? gnt_idx : '0;
    end

    always_comb begin
`ifdef ZAP_TAG_CTRL_FWD_EN
        if (fwd_v) begin
            hit_raw = (fwd_tag == pend_tag);
        end else begin
            hit_raw = i_mem_rdav & (i_mem_rdata == pend_tag);
        end
`else
        hit_raw = i_mem_rdav & (i_mem_rdata == pend_tag);
`endif
        o_rsp_valid = active & pend_v;
        o_rsp_id    = active & pend_v & pend_id;
        o_rsp_hit   = active & pend_v & hit_raw;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pend_v   <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            pend_v <= gnt_any;
            if (gnt_any) begin
                last_gnt <= gnt1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (gnt_any) begin
            pend_id  <= gnt1;
            pend_tag <= gnt_tag;
        end
    end

`ifdef ZAP_TAG_CTRL_FWD_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fwd_v <= 1'b0;
        end else begin
            fwd_v <= gnt_any & wr_c & (gnt_idx == i_wr_idx);
        end
    end

    always_ff @(posedge i_clk) begin
        fwd_tag <= i_wr_tag;
    end
`endif

endmodule

// File: tb/tb_zap_tag_ram_ctrl.sv
// Scoreboard bench for zap_tag_ram_ctrl with a behavioural tag RAM and cache model.
module tb_zap_tag_ram_ctrl;

    localparam int DEPTH = 32;
    localparam int WIDTH = 32;
    localparam int IDXW  = $clog2(DEPTH);
`ifdef ZAP_TAG_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1;
    logic [IDXW-1:0]  idx0, idx1;
    logic [WIDTH-1:0] tag0, tag1;
    logic             gnt0, gnt1;
    logic             rsp_valid, rsp_id, rsp_hit;
    logic             wr_req;
    logic [IDXW-1:0]  wr_idx;
    logic [WIDTH-1:0] wr_tag;
    logic             wr_ack;
    logic             inv_req, inv_ack;
    logic             mem_ren, mem_wen, mem_inv;
    logic [IDXW-1:0]  mem_raddr, mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    bit   [WIDTH-1:0] mem_rdata;
    bit               mem_rdav;

    zap_tag_ram_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_req0(req0), .i_idx0(idx0), .i_tag0(tag0),
        .i_req1(req1), .i_idx1(idx1), .i_tag1(tag1),
        .o_gnt0(gnt0), .o_gnt1(gnt1),
        .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_hit(rsp_hit),
        .i_wr_req(wr_req), .i_wr_idx(wr_idx), .i_wr_tag(wr_tag), .o_wr_ack(wr_ack),
        .i_inv_req(inv_req), .o_inv_ack(inv_ack),
        .o_mem_ren(mem_ren), .o_mem_wen(mem_wen), .o_mem_inv(mem_inv),
        .o_mem_raddr(mem_raddr), .o_mem_waddr(mem_waddr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .i_mem_rdav(mem_rdav)
    );

    always #5 clk = ~clk;

    // Tag RAM: 1-cycle read latency, single-cycle clear of all valid bits.
    bit [WIDTH-1:0] ram_tag [DEPTH];
    bit             ram_v   [DEPTH];

    always @(posedge clk) begin
        if (mem_inv) begin
            for (int i = 0; i < DEPTH; i++) ram_v[i] <= 1'b0;
        end else if (mem_wen) begin
            ram_v[mem_waddr]   <= 1'b1;
            ram_tag[mem_waddr] <= mem_wdata;
        end
        if (mem_ren) begin
            mem_rdata <= ram_tag[mem_raddr];
            mem_rdav  <= ram_v[mem_raddr];
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    typedef struct {
        bit id;
        bit hit;
        int cyc;
    } exp_t;

    exp_t q[$];

    // Reference state: contents of the cache as seen by lookups, and arbiter history.
    bit [WIDTH-1:0] m_tag   [DEPTH];
    bit             m_valid [DEPTH];
    int             m_last = 1;
    bit gs0, gs1, ws, is;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bit inv, wr, e0, e1, h;
        int g;
        logic [IDXW-1:0]  ri;
        logic [WIDTH-1:0] rt;
        gs0 = gnt0;
        gs1 = gnt1;
        ws  = wr_ack;
        is  = inv_ack;
        if (rst) begin
            chk("rst_gnt0", gnt0, 0);
            chk("rst_gnt1", gnt1, 0);
            chk("rst_wr_ack", wr_ack, 0);
            chk("rst_inv_ack", inv_ack, 0);
            chk("rst_mem_ren", mem_ren, 0);
            chk("rst_mem_wen", mem_wen, 0);
            chk("rst_mem_inv", mem_inv, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            q.delete();
            m_last = 1;
        end else begin
            inv = inv_req;
            wr  = wr_req && !inv_req;
            e0  = req0 && !inv && (FWD || !(wr && idx0 == wr_idx));
            e1  = req1 && !inv && (FWD || !(wr && idx1 == wr_idx));
            if (e0 && e1) g = (m_last == 0) ? 1 : 0;
            else if (e0) g = 0;
            else if (e1) g = 1;
            else g = -1;
            chk("inv_ack", inv_ack, inv);
            chk("mem_inv", mem_inv, inv);
            chk("wr_ack", wr_ack, wr);
            chk("mem_wen", mem_wen, wr);
            chk("gnt0", gnt0, g == 0);
            chk("gnt1", gnt1, g == 1);
            chk("mem_ren", mem_ren, g >= 0);
            if (wr) begin
                chk("mem_waddr", mem_waddr, wr_idx);
                chk("mem_wdata", mem_wdata, wr_tag);
            end
            if (g >= 0) begin
                ri = (g == 1) ? idx1 : idx0;
                rt = (g == 1) ? tag1 : tag0;
                chk("mem_raddr", mem_raddr, ri);
                if (FWD && wr && ri == wr_idx) h = (wr_tag == rt);
                else h = m_valid[ri] && (m_tag[ri] == rt);
                q.push_back('{id: g[0], hit: h, cyc: cyc});
                m_last = g;
            end
            if (inv) begin
                for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            end else if (wr) begin
                m_valid[wr_idx] = 1'b1;
                m_tag[wr_idx]   = wr_tag;
            end
        end
    end

    // Monitor: every grant owes exactly one response in the following cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (q.size() > 0 && q[0].cyc == cyc - 1) begin
                e = q.pop_front();
                chk("rsp_valid", rsp_valid, 1);
                if (rsp_valid) begin
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_hit", rsp_hit, e.hit);
                end
            end else if (rsp_valid) begin
                chk("rsp_spurious", rsp_valid, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (gs0) req0 = 1'b0;
        if (gs1) req1 = 1'b0;
        if (ws) wr_req = 1'b0;
        if (is) inv_req = 1'b0;
    endtask

    task automatic rd0(input int i, input int t);
        req0 = 1'b1; idx0 = IDXW'(i); tag0 = WIDTH'(t);
    endtask

    task automatic rd1(input int i, input int t);
        req1 = 1'b1; idx1 = IDXW'(i); tag1 = WIDTH'(t);
    endtask

    task automatic wrt(input int i, input int t);
        wr_req = 1'b1; wr_idx = IDXW'(i); wr_tag = WIDTH'(t);
    endtask

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; idx0 = 0; idx1 = 0; tag0 = 0; tag1 = 0;
        wr_req = 0; wr_idx = 0; wr_tag = 0; inv_req = 0;
        tick();
        rd0(1, 1); wrt(1, 1); inv_req = 1'b1;
        tick();
        tick();
        req0 = 0; wr_req = 0; inv_req = 0;
        rst = 1'b0;

        // Single lookups: hit then miss.
        wrt(5, 'hABCD);
        tick();
        rd0(5, 'hABCD);
        tick(); tick();
        rd0(5, 'h1234);
        tick(); tick();

        // Both requesters held continuously.
        for (int i = 0; i < 4; i++) begin
            rd0(5, 'hABCD);
            rd1(5, 'h1234);
            tick();
        end
        req0 = 0; req1 = 0;
        tick(); tick();

        // Invalidate beats write beats read.
        wrt(3, 'h33);
        tick();
        inv_req = 1'b1;
        wrt(3, 'h77);
        rd1(3, 'h77);
        repeat (5) tick();

        // Same-index and different-index refill alongside a lookup.
        wrt(7, 'h55);
        rd0(7, 'h55);
        repeat (4) tick();
        wrt(2, 'h22);
        rd0(9, 0);
        repeat (3) tick();

        // Reset while a response is in flight.
        rd1(7, 'h55);
        tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        rd0(7, 'h55);
        rd1(2, 'h22);
        repeat (4) tick();

        for (int n = 0; n < 600; n++) begin
            if (!req0 && $urandom_range(0, 1) == 1)
                rd0($urandom_range(0, 7), $urandom_range(0, 3));
            if (!req1 && $urandom_range(0, 1) == 1)
                rd1($urandom_range(0, 7), $urandom_range(0, 3));
            if (!wr_req && $urandom_range(0, 3) == 0)
                wrt($urandom_range(0, 7), $urandom_range(0, 3));
            if (!inv_req && $urandom_range(0, 31) == 0)
                inv_req = 1'b1;
            tick();
        end
        req0 = 0; req1 = 0; wr_req = 0; inv_req = 0;
        repeat (3) tick();
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
